// File: rtl/avalon_msg_truncator_pkg.sv
// avalon_msg_truncator_pkg: shared FSM state type, default message bound and width helper
package avalon_msg_truncator_pkg;
  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
  localparam int MAX_MSG_WORDS_DEF = 16;
  function automatic int empty_w(input int bytes);
    return bytes > 1 ? $clog2(bytes) : 1;
  endfunction
endpackage

// File: rtl/avalon_st_if.sv
// avalon_st_if: Avalon-ST packet stream with sop/eop/empty framing
interface avalon_st_if import avalon_msg_truncator_pkg::*; #(parameter int DATA_WIDTH_IN_BYTES = 8);
  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic sop, eop, valid, ready;
  logic [empty_w(DATA_WIDTH_IN_BYTES)-1:0] empty;
  modport master(output data, sop, eop, empty, valid, input ready);
  modport slave(input data, sop, eop, empty, valid, output ready);
endinterface

// File: rtl/avalon_msg_truncator.sv
// avalon_msg_truncator: bounds each message to MAX_MSG_WORDS beats, drops strays and overflow
module avalon_msg_truncator import avalon_msg_truncator_pkg::*; #(
  parameter int DATA_WIDTH_IN_BYTES = 8,
  parameter int MAX_MSG_WORDS = MAX_MSG_WORDS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  avalon_st_if.slave  in_msg,
  avalon_st_if.master out_msg,
  output logic       truncated_error,
  output logic       stray_word_error,
  output logic       msg_done,
  output logic [7:0] msg_words
);
  state_t st;
  logic [7:0] cnt, cnt1, words_q;
  logic acc, fwd, cut;
  // DROP swallows beats regardless of the output stage so a stalled sink cannot block discard
  assign in_msg.ready = st == DROP || !out_msg.valid || out_msg.ready;
  assign acc = in_msg.valid && in_msg.ready;
  assign cnt1 = cnt + 8'd1;
  assign cut = st == PASS && !in_msg.eop && cnt1 == 8'(MAX_MSG_WORDS);
  assign fwd = acc && (st == PASS || (st == IDLE && in_msg.sop));
  assign truncated_error = !rst && acc && cut;
  assign stray_word_error = !rst && acc && st == IDLE && !in_msg.sop;
  assign msg_done = !rst && fwd && (in_msg.eop || cut);
  assign msg_words = rst ? '0 : msg_done ? (st == IDLE ? 8'd1 : cnt1) : words_q;
  // message framing FSM and beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      words_q <= '0;
    end else begin
      if (msg_done) words_q <= msg_words;
      if (acc) begin
        st <= st == IDLE ? (in_msg.sop && !in_msg.eop ? PASS : IDLE)
            : st == PASS ? (in_msg.eop ? IDLE : cut ? DROP : PASS)
            : (in_msg.eop ? IDLE : DROP);
        cnt <= (st == IDLE && in_msg.sop && !in_msg.eop) ? 8'd1
             : (st == PASS && !in_msg.eop && !cut) ? cnt1 : 8'd0;
      end
    end
  end
  // single output register; a cut beat is closed with eop and a full last word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_msg.valid <= 1'b0;
      out_msg.sop <= 1'b0;
      out_msg.eop <= 1'b0;
      out_msg.data <= '0;
      out_msg.empty <= '0;
    end else if (fwd) begin
      out_msg.valid <= 1'b1;
      out_msg.sop <= st == IDLE;
      out_msg.eop <= in_msg.eop || cut;
      out_msg.data <= in_msg.data[8*DATA_WIDTH_IN_BYTES-1:0];
      out_msg.empty <= cut ? '0 : in_msg.empty;
    end else if (out_msg.ready) begin
      out_msg.valid <= 1'b0;
    end
  end
endmodule
